// File: rtl/rs232_des_gen_if.sv
// Character handshake bundle between the RS-232 receiver and its consumer.
// The slave side owns the serial line and the acknowledge.
interface rs232_des_gen_if #(
   parameter int P_DATA_BITS = 8
) ();
   logic                   rx;
   logic [P_DATA_BITS-1:0] rx_data;
   logic                   rx_req;
   logic                   rx_ack;
   logic                   rx_perr;
   logic                   rx_ferr;
   logic                   rx_break;
   logic                   rx_overrun;

   modport master (
      input  rx,
      input  rx_ack,
      output rx_data,
      output rx_req,
      output rx_perr,
      output rx_ferr,
      output rx_break,
      output rx_overrun
   );

   modport slave (
      output rx,
      output rx_ack,
      input  rx_data,
      input  rx_req,
      input  rx_perr,
      input  rx_ferr,
      input  rx_break,
      input  rx_overrun
   );
endinterface

// File: rtl/rs232_des_gen.sv
// Parametrised RS-232 receiver: 3-sample majority voting, false-start rejection,
// parity/framing/break/overrun status and a req/ack character handshake.
module rs232_des_gen #(
   parameter int P_CLK_FREQ_HZ = 100000000,
   parameter int P_BAUD_RATE   = 9600,
   parameter int P_DATA_BITS   = 8,
   parameter int P_PARITY      = 0,
   parameter int P_STOP_BITS   = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   rs232_des_gen_if.master bus
);

   localparam int BIT_CNT = P_CLK_FREQ_HZ / P_BAUD_RATE;
   localparam int HALF    = BIT_CNT / 2;
   localparam int CNT_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_SMPA = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_SMPB = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);

   localparam logic [3:0] IDX_ZERO      = 4'd0;
   localparam logic [3:0] IDX_ONE       = 4'd1;
   localparam logic [3:0] IDX_DATA_LAST = 4'(P_DATA_BITS - 1);
   localparam logic [3:0] IDX_STOP_LAST = 4'(P_STOP_BITS - 1);

   localparam logic PAR_EN  = (P_PARITY != 0);
   localparam logic PAR_ODD = (P_PARITY == 1);

   localparam logic [P_DATA_BITS-1:0] DATA_ZERO = {P_DATA_BITS{1'b0}};

   generate
      if (BIT_CNT < 8) begin : g_chk_bit_cnt
         $error("rs232_des_gen: clock/baud ratio must be at least 8");
      end
      if ((P_DATA_BITS < 5) || (P_DATA_BITS > 9)) begin : g_chk_data_bits
         $error("rs232_des_gen: P_DATA_BITS must be 5..9");
      end
      if ((P_PARITY < 0) || (P_PARITY > 2)) begin : g_chk_parity
         $error("rs232_des_gen: P_PARITY must be 0, 1 or 2");
      end
      if ((P_STOP_BITS < 1) || (P_STOP_BITS > 2)) begin : g_chk_stop_bits
         $error("rs232_des_gen: P_STOP_BITS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Expected parity bit: XOR of the data, inverted for odd parity
   function automatic logic parity_exp(input logic [P_DATA_BITS-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   logic                   rx_meta_r, rx_s_r, rx_s_d1_r;
   state_t                 state_r, state_nxt_s;
   logic [CNT_W-1:0]       cnt_r, cnt_nxt_s, cnt_inc_s;
   logic [3:0]             bit_idx_r, bit_idx_nxt_s;
   logic [1:0]             smp_r, smp_nxt_s;
   logic [P_DATA_BITS-1:0] shift_r, shift_nxt_s;
   logic                   par_bit_r, par_bit_nxt_s;
   logic                   perr_pend_r, perr_pend_nxt_s;
   logic                   ferr_pend_r, ferr_pend_nxt_s;
   logic                   stop_one_r, stop_one_nxt_s;
   logic                   fall_s, maj_s, dec_s, bnd_s, done_s;

   logic [P_DATA_BITS-1:0] rx_data_r, rx_data_nxt_s;
   logic                   rx_req_r, rx_req_nxt_s;
   logic                   rx_perr_r, rx_perr_nxt_s;
   logic                   rx_ferr_r, rx_ferr_nxt_s;
   logic                   rx_break_r, rx_break_nxt_s;
   logic                   rx_overrun_r, rx_overrun_nxt_s;
   logic                   frm_perr_s, frm_ferr_s, frm_brk_s;

   // Two-flop synchroniser plus one delay stage for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_r <= 1'b1;
         rx_s_r    <= 1'b1;
         rx_s_d1_r <= 1'b1;
      end else begin
         rx_meta_r <= bus.rx;
         rx_s_r    <= rx_meta_r;
         rx_s_d1_r <= rx_s_r;
      end
   end

   assign fall_s = rx_s_d1_r & ~rx_s_r;
   assign maj_s  = maj3(smp_r[0], smp_r[1], rx_s_r);
   assign dec_s  = (cnt_r == CNT_DEC);
   assign bnd_s  = (cnt_r == CNT_LAST);

   // Frame FSM next-state and sampling datapath
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      bit_idx_nxt_s   = bit_idx_r;
      smp_nxt_s       = smp_r;
      shift_nxt_s     = shift_r;
      par_bit_nxt_s   = par_bit_r;
      perr_pend_nxt_s = perr_pend_r;
      ferr_pend_nxt_s = ferr_pend_r;
      stop_one_nxt_s  = stop_one_r;
      done_s          = 1'b0;

      if (bnd_s) begin
         cnt_inc_s = CNT_ZERO;
      end else begin
         cnt_inc_s = cnt_r + CNT_ONE;
      end

      if (cnt_r == CNT_SMPA) begin
         smp_nxt_s[0] = rx_s_r;
      end else if (cnt_r == CNT_SMPB) begin
         smp_nxt_s[1] = rx_s_r;
      end else begin
         smp_nxt_s = smp_r;
      end

      case (state_r)
         ST_IDLE: begin
            cnt_nxt_s     = CNT_ZERO;
            bit_idx_nxt_s = IDX_ZERO;
            if (fall_s) begin
               state_nxt_s     = ST_START;
               par_bit_nxt_s   = 1'b0;
               perr_pend_nxt_s = 1'b0;
               ferr_pend_nxt_s = 1'b0;
               stop_one_nxt_s  = 1'b0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            cnt_nxt_s = cnt_inc_s;
            if (dec_s && maj_s) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end else if (bnd_s) begin
               state_nxt_s   = ST_DATA;
               bit_idx_nxt_s = IDX_ZERO;
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_DATA: begin
            cnt_nxt_s = cnt_inc_s;
            if (dec_s) begin
               shift_nxt_s = {maj_s, shift_r[P_DATA_BITS-1:1]};
            end else begin
               shift_nxt_s = shift_r;
            end
            if (bnd_s && (bit_idx_r == IDX_DATA_LAST)) begin
               bit_idx_nxt_s = IDX_ZERO;
               state_nxt_s   = PAR_EN ? ST_PARITY : ST_STOP;
            end else if (bnd_s) begin
               bit_idx_nxt_s = bit_idx_r + IDX_ONE;
            end else begin
               bit_idx_nxt_s = bit_idx_r;
            end
         end
         ST_PARITY: begin
            cnt_nxt_s = cnt_inc_s;
            if (dec_s) begin
               par_bit_nxt_s   = maj_s;
               perr_pend_nxt_s = maj_s ^ parity_exp(shift_r, PAR_ODD);
            end else if (bnd_s) begin
               state_nxt_s   = ST_STOP;
               bit_idx_nxt_s = IDX_ZERO;
            end else begin
               state_nxt_s = ST_PARITY;
            end
         end
         ST_STOP: begin
            cnt_nxt_s = cnt_inc_s;
            // Finish on the last stop decision so the next start edge can resync
            if (dec_s) begin
               ferr_pend_nxt_s = ferr_pend_r | ~maj_s;
               stop_one_nxt_s  = stop_one_r | maj_s;
               if (bit_idx_r == IDX_STOP_LAST) begin
                  done_s        = 1'b1;
                  state_nxt_s   = ST_IDLE;
                  cnt_nxt_s     = CNT_ZERO;
                  bit_idx_nxt_s = IDX_ZERO;
               end else begin
                  state_nxt_s = ST_STOP;
               end
            end else if (bnd_s) begin
               bit_idx_nxt_s = bit_idx_r + IDX_ONE;
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            cnt_nxt_s     = CNT_ZERO;
            bit_idx_nxt_s = IDX_ZERO;
         end
      endcase
   end

   assign frm_perr_s = PAR_EN & perr_pend_r;
   assign frm_ferr_s = ferr_pend_r | ~maj_s;
   assign frm_brk_s  = (shift_r == DATA_ZERO) & (~PAR_EN | ~par_bit_r) & ~stop_one_r & ~maj_s;

   // Frame completion and req/ack handshake for the held character
   always_comb begin
      rx_data_nxt_s    = rx_data_r;
      rx_req_nxt_s     = rx_req_r;
      rx_perr_nxt_s    = rx_perr_r;
      rx_ferr_nxt_s    = rx_ferr_r;
      rx_break_nxt_s   = rx_break_r;
      rx_overrun_nxt_s = rx_overrun_r;

      if (done_s) begin
         if (!rx_req_r || bus.rx_ack) begin
            rx_data_nxt_s    = shift_r;
            rx_perr_nxt_s    = frm_perr_s;
            rx_ferr_nxt_s    = frm_ferr_s;
            rx_break_nxt_s   = frm_brk_s;
            rx_req_nxt_s     = 1'b1;
            rx_overrun_nxt_s = 1'b0;
         end else begin
            rx_overrun_nxt_s = 1'b1;
         end
      end else if (rx_req_r && bus.rx_ack) begin
         rx_req_nxt_s     = 1'b0;
         rx_overrun_nxt_s = 1'b0;
      end else begin
         rx_req_nxt_s = rx_req_r;
      end
   end

   // FSM state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         bit_idx_r   <= IDX_ZERO;
         smp_r       <= 2'b11;
         shift_r     <= DATA_ZERO;
         par_bit_r   <= 1'b0;
         perr_pend_r <= 1'b0;
         ferr_pend_r <= 1'b0;
         stop_one_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         bit_idx_r   <= bit_idx_nxt_s;
         smp_r       <= smp_nxt_s;
         shift_r     <= shift_nxt_s;
         par_bit_r   <= par_bit_nxt_s;
         perr_pend_r <= perr_pend_nxt_s;
         ferr_pend_r <= ferr_pend_nxt_s;
         stop_one_r  <= stop_one_nxt_s;
      end
   end

   // Registered character and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_r    <= DATA_ZERO;
         rx_req_r     <= 1'b0;
         rx_perr_r    <= 1'b0;
         rx_ferr_r    <= 1'b0;
         rx_break_r   <= 1'b0;
         rx_overrun_r <= 1'b0;
      end else begin
         rx_data_r    <= rx_data_nxt_s;
         rx_req_r     <= rx_req_nxt_s;
         rx_perr_r    <= rx_perr_nxt_s;
         rx_ferr_r    <= rx_ferr_nxt_s;
         rx_break_r   <= rx_break_nxt_s;
         rx_overrun_r <= rx_overrun_nxt_s;
      end
   end

   assign bus.rx_data    = rx_data_r;
   assign bus.rx_req     = rx_req_r;
   assign bus.rx_perr    = rx_perr_r;
   assign bus.rx_ferr    = rx_ferr_r;
   assign bus.rx_break   = rx_break_r;
   assign bus.rx_overrun = rx_overrun_r;

endmodule

// File: doc/rs232_des_gen.md
Name: rs232_des_gen

Overview:
- Parametrised RS-232 receiver; next generation of the fixed 8N1 deserializer.
- Adds configurable data width, parity, and 1 or 2 stop bits.
- Adds 3-sample majority voting, false-start rejection, and parity/framing/break/overrun status.
- Sits between the board RX pin and the command parser, using the same req/ack character handshake.

Parameters:
- P_CLK_FREQ_HZ, 100000000, system clock frequency.
- P_BAUD_RATE, 9600, line rate.
- P_DATA_BITS, 8, data bits per frame; legal 5..9.
- P_PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- P_STOP_BITS, 1, stop bits; legal 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- rx  in  1  asynchronous serial line; idle/mark = 1, start bit = 0.
- rx_data  out  P_DATA_BITS  received character, LSB first on the line.
- rx_req  out  1  character valid; held until acknowledged.
- rx_ack  in  1  downstream acceptance.
- rx_perr  out  1  parity error for the character on rx_data.
- rx_ferr  out  1  framing error: a stop bit was sampled 0.
- rx_break  out  1  break: the whole frame, including stop bits, was 0.
- rx_overrun  out  1  at least one frame was dropped while rx_req was high.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low. Reset values: every output 0, state IDLE, counters 0.
- Synchroniser: rx passes through a 2-FF synchroniser (rx_s), reset value 1. A falling edge is rx_s_d1 = 1 and rx_s = 0.
- Timing constants:
  - BIT_CNT = P_CLK_FREQ_HZ / P_BAUD_RATE. Elaboration error if BIT_CNT < 8.
  - HALF = BIT_CNT / 2.
  - Counter cnt is clogb2(BIT_CNT) bits wide, counts 0..BIT_CNT-1, then wraps to 0 (bit boundary).
- Sampling: in each bit, samples are taken at cnt = HALF-1, HALF and HALF+1. The bit value is the majority of the three and is decided at cnt = HALF+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: cnt = 0, bit index = 0. On a falling edge go to START; cnt begins counting on the next cycle.
- START:
  - Majority 1 at decision → false start; return to IDLE, no output change.
  - Otherwise continue to the bit boundary, then go to DATA.
- DATA:
  - At each decision, shift the bit into the shift register LSB first.
  - At the boundary of bit P_DATA_BITS-1, go to PARITY if P_PARITY != 0, else STOP.
- PARITY:
  - Expected bit is XOR of the data bits; invert it for odd parity.
  - perr_pend = (sampled bit != expected). Go to STOP at the boundary.
- STOP:
  - Sample P_STOP_BITS bits. Any 0 sets ferr_pend.
  - At the decision point of the last stop bit (not its boundary, to allow resync on the next start edge), do the frame completion step and go to IDLE.
  - Break: data all 0, parity bit 0 (if present), all stop bits 0 → rx_break = 1 and rx_ferr = 1. IDLE needs a real 1→0 edge, so a held-low line does not retrigger.
- Frame completion:
  - If rx_req = 0: load rx_data, rx_perr, rx_ferr, rx_break on the next edge and set rx_req = 1.
  - If rx_req = 1 and rx_ack = 1 in the same cycle: the old frame counts as accepted. Load the new frame, rx_req stays 1, rx_overrun is not set.
  - If rx_req = 1 and rx_ack = 0: discard the new frame, keep the held outputs, set rx_overrun = 1.
- Handshake:
  - rx_req clears on the cycle after rx_ack is sampled high.
  - rx_overrun clears with it.
  - rx_ack while rx_req = 0 is ignored.
  - rx_data and the status outputs are stable while rx_req = 1.
- Latency: rx_req rises 1 cycle after the last stop-bit decision, about (frame_bits - 0.5) bit times after the start edge plus the 2-cycle synchroniser.
- Reset mid-frame: state returns to IDLE immediately and outputs go to 0. After release, a line still low mid-frame can produce at most one spurious frame; that frame must not lock up the FSM.

Test Plan:
Bench settings: P_CLK_FREQ_HZ = 1000000, P_BAUD_RATE = 62500 (BIT_CNT = 16).
1. Defaults 8N1, send 0xA5 → rx_data = 0xA5, rx_req = 1, perr/ferr/break/overrun = 0. Assert rx_ack one cycle → rx_req = 0 next cycle.
2. P_DATA_BITS = 7, P_PARITY = 2. Send 0x41 with parity 0 → rx_perr = 0. Send 0x41 with parity 1 → rx_data = 0x41, rx_perr = 1.
3. 8N1, send 0x3C with stop bit forced 0 → rx_ferr = 1, rx_break = 0. Send all-zero frame with stop 0 → rx_ferr = 1, rx_break = 1. A following 0x55 after line idle → 0x55, no error flags.
4. Send 0x11, then 0x22 and 0x33 with no ack → rx_data = 0x11, rx_overrun = 1. Ack → both clear. Send 0x44 with ack asserted at the completion cycle → 0x44 loaded, rx_req stays high, rx_overrun = 0.
5. Glitches:
   - rx low for 4 clocks → no rx_req, FSM back in IDLE by cnt = HALF+1.
   - 1-clock inverted glitch at cnt = HALF of data bit 3 in 0x00 → rx_data = 0x00.
6. P_STOP_BITS = 2, second stop bit 0 → rx_ferr = 1. Assert rst_n low mid-data-bit → all outputs 0. After release, a clean 0x7E → rx_data = 0x7E with no error flags.
